// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - shared widths, constants and FSM encodings for the ARP resolver
// Purpose: common definitions imported by arp_resolver and arp_resolver_timer.
// Ports: none (package).
package arp_pkg;

    localparam int IP_W  = 32;
    localparam int MAC_W = 48;

    localparam logic [MAC_W-1:0] MAC_ZERO  = 48'h0;
    localparam logic [MAC_W-1:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SEEK       = 3'd1;
    localparam logic [2:0] ST_WAIT_TAB   = 3'd2;
    localparam logic [2:0] ST_ARP_REQ    = 3'd3;
    localparam logic [2:0] ST_WAIT_REPLY = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;
    localparam logic [2:0] ST_FAIL       = 3'd6;

    // The ARP table reports a miss as an all-zero MAC.
    function automatic logic mac_is_hit(input logic [MAC_W-1:0] mac);
        return mac != MAC_ZERO;
    endfunction

endpackage

// File: rtl/arp_resolver_timer.sv
// rtl/arp_resolver_timer.sv - 32-bit saturating up-counter with terminal count
// Purpose: wait counter for table lookups and ARP reply timeouts.
// Ports:
//   clk  in  1  clock
//   rst  in  1  synchronous active-high reset
//   clr  in  1  synchronous clear (wins over en)
//   en   in  1  count enable
//   tc   out 1  high while the count equals P_TC
module arp_resolver_timer #(
    parameter logic [31:0] P_TC = 32'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [31:0] cnt;

    // Saturates at all-ones so a stalled FSM can never see the count wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != 32'hFFFF_FFFF)) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign tc = (cnt == P_TC);

endmodule

// File: rtl/arp_resolver.sv
// rtl/arp_resolver.sv - resolves a next-hop IP to a MAC via ARP table and ARP requests
// Purpose: looks up the ARP table, falls back to ARP requests with retry on timeout,
//          returns the MAC (o_res_valid) or a failure pulse (o_res_fail).
// Optional: define ARP_RESOLVER_CACHE_EN for a one-entry {ip, mac} result cache.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_req_ip/i_req_valid/o_req_ready  resolve request (accepted in IDLE only)
//   o_res_mac/o_res_valid/o_res_fail  result pulses, MAC is 0 on fail
//   o_seek_ip/o_seek_valid            table lookup strobe
//   i_tab_mac/i_tab_valid             table result (0 = miss)
//   o_arp_ip/o_arp_req                ARP TX active-request pulse
//   i_upd_ip/i_upd_mac/i_upd_valid    learned mapping from ARP RX
module arp_resolver
    import arp_pkg::*;
#(
    parameter int unsigned P_TAB_WAIT    = 8,
    parameter int unsigned P_ARP_TIMEOUT = 125_000_000,
    parameter int unsigned P_RETRY       = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IP_W-1:0]  i_req_ip,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    output logic [MAC_W-1:0] o_res_mac,
    output logic             o_res_valid,
    output logic             o_res_fail,
    output logic [IP_W-1:0]  o_seek_ip,
    output logic             o_seek_valid,
    input  logic [MAC_W-1:0] i_tab_mac,
    input  logic             i_tab_valid,
    output logic [IP_W-1:0]  o_arp_ip,
    output logic             o_arp_req,
    input  logic [IP_W-1:0]  i_upd_ip,
    input  logic [MAC_W-1:0] i_upd_mac,
    input  logic             i_upd_valid
);

    localparam int RW = $clog2(P_RETRY + 1);

    logic [2:0]       state, state_nxt;
    logic [IP_W-1:0]  ip, ip_nxt;
    logic [MAC_W-1:0] mac_nxt;
    logic [RW-1:0]    retry_cnt;
    logic             tab_tc, reply_tc;
    logic             upd_hit;
    logic             cache_hit;
    logic [MAC_W-1:0] cache_mac;

    arp_resolver_timer #(.P_TC(32'(P_TAB_WAIT - 1))) u_tab_timer (
        .clk (i_clk),
        .rst (i_rst),
        .clr (state == ST_SEEK),
        .en  (state == ST_WAIT_TAB),
        .tc  (tab_tc)
    );

    arp_resolver_timer #(.P_TC(32'(P_ARP_TIMEOUT - 1))) u_reply_timer (
        .clk (i_clk),
        .rst (i_rst),
        .clr (state == ST_ARP_REQ),
        .en  (state == ST_WAIT_REPLY),
        .tc  (reply_tc)
    );

    assign upd_hit = i_upd_valid && (i_upd_ip == ip);

    always_comb begin
        state_nxt = state;
        ip_nxt    = ip;
        mac_nxt   = MAC_ZERO;
        case (state)
            ST_IDLE: begin
                if (o_req_ready && i_req_valid) begin
                    ip_nxt    = i_req_ip;
                    state_nxt = ST_SEEK;
                    if (cache_hit) begin
                        state_nxt = ST_DONE;
                        mac_nxt   = cache_mac;
                    end
                end
            end
            ST_SEEK: state_nxt = ST_WAIT_TAB;
            ST_WAIT_TAB: begin
                // A learned update beats the table answer; a miss or a silent table both fall back to ARP.
                if (upd_hit) begin
                    state_nxt = ST_DONE;
                    mac_nxt   = i_upd_mac;
                end else if (i_tab_valid && mac_is_hit(i_tab_mac)) begin
                    state_nxt = ST_DONE;
                    mac_nxt   = i_tab_mac;
                end else if (i_tab_valid || tab_tc) begin
                    state_nxt = ST_ARP_REQ;
                end
            end
            ST_ARP_REQ: state_nxt = ST_WAIT_REPLY;
            ST_WAIT_REPLY: begin
                // Checked before the timeout so a reply on the last cycle still counts.
                if (upd_hit) begin
                    state_nxt = ST_DONE;
                    mac_nxt   = i_upd_mac;
                end else if (reply_tc) begin
                    state_nxt = (retry_cnt == RW'(P_RETRY)) ? ST_FAIL : ST_ARP_REQ;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_FAIL: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every strobe is a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            ip           <= '0;
            retry_cnt    <= '0;
            o_req_ready  <= 1'b0;
            o_res_mac    <= MAC_ZERO;
            o_res_valid  <= 1'b0;
            o_res_fail   <= 1'b0;
            o_seek_ip    <= '0;
            o_seek_valid <= 1'b0;
            o_arp_ip     <= '0;
            o_arp_req    <= 1'b0;
        end else begin
            state        <= state_nxt;
            ip           <= ip_nxt;
            o_req_ready  <= (state_nxt == ST_IDLE);
            o_seek_valid <= (state_nxt == ST_SEEK);
            o_arp_req    <= (state_nxt == ST_ARP_REQ);
            o_res_valid  <= (state_nxt == ST_DONE);
            o_res_fail   <= (state_nxt == ST_FAIL);
            o_res_mac    <= (state_nxt == ST_DONE) ? mac_nxt : MAC_ZERO;
            if (state_nxt == ST_SEEK) begin
                o_seek_ip <= ip_nxt;
            end
            if (state_nxt == ST_ARP_REQ) begin
                o_arp_ip <= ip_nxt;
            end
            if (state == ST_IDLE) begin
                retry_cnt <= '0;
            end else if (state_nxt == ST_ARP_REQ) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
        end
    end

`ifdef ARP_RESOLVER_CACHE_EN
    logic [IP_W-1:0] cache_ip;
    logic            cache_vld;

    assign cache_hit = cache_vld && (cache_ip == i_req_ip);

    // Later statements win: a new result overrides an update or invalidation in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cache_ip  <= '0;
            cache_mac <= MAC_ZERO;
            cache_vld <= 1'b0;
        end else begin
            if (cache_vld && i_upd_valid && (i_upd_ip == cache_ip)) begin
                cache_mac <= i_upd_mac;
            end
            if ((state_nxt == ST_FAIL) && (ip == cache_ip)) begin
                cache_vld <= 1'b0;
            end
            if (state_nxt == ST_DONE) begin
                cache_ip  <= ip_nxt;
                cache_mac <= mac_nxt;
                cache_vld <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_mac = MAC_ZERO;
`endif

endmodule

// File: tb/tb_arp_resolver.sv
// tb/tb_arp_resolver.sv - directed scoreboard bench for arp_resolver
module tb_arp_resolver;

    localparam logic [31:0] IP2  = 32'hC0A8_0A02;
    localparam logic [31:0] IP9  = 32'hC0A8_0A09;
    localparam logic [47:0] MAC1 = 48'h000A_3501_0203;
    localparam logic [47:0] MAC2 = 48'hAABB_CCDD_EEFF;
    localparam logic [47:0] MAC3 = 48'h0211_2233_4455;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req_ip = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [47:0] res_mac;
    logic        res_valid, res_fail;
    logic [31:0] seek_ip;
    logic        seek_valid;
    logic [47:0] tab_mac = '0;
    logic        tab_valid = 1'b0;
    logic [31:0] arp_ip;
    logic        arp_req;
    logic [31:0] upd_ip = '0;
    logic [47:0] upd_mac = '0;
    logic        upd_valid = 1'b0;

    arp_resolver #(.P_TAB_WAIT(8), .P_ARP_TIMEOUT(100), .P_RETRY(3)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_ip(req_ip), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .o_res_mac(res_mac), .o_res_valid(res_valid), .o_res_fail(res_fail),
        .o_seek_ip(seek_ip), .o_seek_valid(seek_valid),
        .i_tab_mac(tab_mac), .i_tab_valid(tab_valid),
        .o_arp_ip(arp_ip), .o_arp_req(arp_req),
        .i_upd_ip(upd_ip), .i_upd_mac(upd_mac), .i_upd_valid(upd_valid)
    );

    typedef struct {
        bit          fail;
        logic [47:0] mac;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          arp_stamp[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          arp_cnt = 0;
    int          seek_cnt = 0;
    int          seek_last = -1;
    int          res_cnt = 0;
    logic [31:0] exp_arp_ip = IP2;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stamps are the clock-edge index at which the DUT output is sampled.
    always @(negedge clk) begin
        exp_t e;
        if (seek_valid) begin
            seek_cnt++;
            seek_last = cyc + 1;
            check("seek_ip", seek_ip, IP2);
        end
        if (arp_req) begin
            arp_cnt++;
            arp_stamp.push_back(cyc + 1);
            check("arp_ip", arp_ip, exp_arp_ip);
        end
        if (res_valid || res_fail) begin
            res_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_result observed valid=%0b fail=%0b expected none", res_valid, res_fail);
            end else begin
                e = sb.pop_front();
                check("res_kind", {res_valid, res_fail}, e.fail ? 2'b01 : 2'b10);
                check("res_mac", res_mac, e.mac);
                check("res_cycle", cyc + 1, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = 1'b0;
        tab_valid = 1'b0;
        upd_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic do_req(input logic [31:0] ip, output int acc);
        int n = 0;
        req_ip = ip;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            tick(1);
            n++;
        end
        check("req_ready_wait", n < 20, 1'b1);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic tab_resp(input logic [47:0] mac);
        tab_mac = mac;
        tab_valid = 1'b1;
        tick(1);
        tab_valid = 1'b0;
    endtask

    task automatic upd_pulse(input logic [31:0] ip, input logic [47:0] mac);
        upd_ip = ip;
        upd_mac = mac;
        upd_valid = 1'b1;
        tick(1);
        upd_valid = 1'b0;
    endtask

    task automatic wait_arp(input int target, input int budget, input string tag);
        int n = 0;
        while (arp_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_arp_seen"}, arp_cnt >= target, 1'b1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        int acc, acc2, a0, r0, s0, a1;

        // reset state
        tick(3);
        check("rst_ready", req_ready, 1'b0);
        check("rst_strobes", {res_valid, res_fail, seek_valid, arp_req}, 4'b0);
        check("rst_data", {res_mac, seek_ip, arp_ip}, '0);
        rst = 1'b0;
        tick(1);
        check("rst_ready_after", req_ready, 1'b1);

        // table hit: tab two cycles after seek
        a0 = arp_cnt;
        do_req(IP2, acc);
        tick(2);
        sb.push_back('{fail: 1'b0, mac: MAC1, cyc: acc + 4});
        tab_resp(MAC1);
        check("t1_ready_low", req_ready, 1'b0);
        tick(1);
        check("t1_ready_high", req_ready, 1'b1);
        check("t1_seek_cycle", seek_last, acc + 1);
        check("t1_no_arp", arp_cnt, a0);

        // table miss, reply 40 cycles later
        reset_dut();
        a0 = arp_cnt;
        do_req(IP2, acc);
        tick(2);
        tab_resp(MAC_ZERO_TB());
        wait_arp(a0 + 1, 10, "t2");
        check("t2_arp_cycle", arp_stamp[a0], acc + 4);
        tick(40);
        check("t2_busy_not_ready", req_ready, 1'b0);
        sb.push_back('{fail: 1'b0, mac: MAC2, cyc: cyc + 2});
        upd_pulse(IP2, MAC2);
        wait_idle(10, "t2");
        check("t2_one_arp", arp_cnt, a0 + 1);

        // no reply (foreign update ignored): three requests then fail
        reset_dut();
        a0 = arp_cnt;
        do_req(IP2, acc);
        tick(2);
        tab_resp(MAC_ZERO_TB());
        wait_arp(a0 + 1, 10, "t3a");
        tick(30);
        upd_pulse(IP9, MAC3);
        wait_arp(a0 + 3, 400, "t3b");
        sb.push_back('{fail: 1'b1, mac: 48'h0, cyc: arp_stamp[a0 + 2] + 101});
        wait_idle(200, "t3");
        check("t3_gap1", arp_stamp[a0 + 1] - arp_stamp[a0], 101);
        check("t3_gap2", arp_stamp[a0 + 2] - arp_stamp[a0 + 1], 101);
        check("t3_arp_total", arp_cnt, a0 + 3);

        // matching update on the timeout cycle wins over the retry
        reset_dut();
        a0 = arp_cnt;
        do_req(IP2, acc);
        tick(2);
        tab_resp(MAC_ZERO_TB());
        wait_arp(a0 + 1, 10, "t4");
        a1 = arp_stamp[a0];
        tick(a1 + 99 - cyc);
        sb.push_back('{fail: 1'b0, mac: MAC3, cyc: a1 + 101});
        upd_pulse(IP2, MAC3);
        wait_idle(20, "t4");
        tick(5);
        check("t4_no_retry", arp_cnt, a0 + 1);

        // silent table -> ARP after 8 cycles; reset during reply wait
        reset_dut();
        a0 = arp_cnt;
        do_req(IP2, acc);
        wait_arp(a0 + 1, 20, "t5");
        check("t5_arp_cycle", arp_stamp[a0], acc + 10);
        tick(10);
        check("t5_busy_not_ready", req_ready, 1'b0);
        r0 = res_cnt;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_rst_ready", req_ready, 1'b0);
        check("t5_rst_strobes", {res_valid, res_fail, seek_valid, arp_req}, 4'b0);
        check("t5_rst_data", {res_mac, seek_ip, arp_ip}, '0);
        tick(1);
        check("t5_ready_back", req_ready, 1'b1);
        tick(150);
        check("t5_no_result", res_cnt, r0);
        check("t5_no_more_arp", arp_cnt, a0 + 1);

`ifdef ARP_RESOLVER_CACHE_EN
        // cache: second request for the same IP skips the seek
        reset_dut();
        do_req(IP2, acc);
        tick(2);
        sb.push_back('{fail: 1'b0, mac: MAC1, cyc: acc + 4});
        tab_resp(MAC1);
        wait_idle(10, "c1");
        s0 = seek_cnt;
        do_req(IP2, acc2);
        sb.push_back('{fail: 1'b0, mac: MAC1, cyc: acc2 + 1});
        wait_idle(10, "c2");
        check("c2_no_seek", seek_cnt, s0);
`else
        s0 = seek_cnt;
        check("seek_total", s0, 5);
`endif

        check("sb_empty_end", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [47:0] MAC_ZERO_TB();
        return 48'h0;
    endfunction

endmodule
